// File: rtl/axis_traffic_gen_mc_if.sv
// Multi-channel AXI-Stream bundle: one packed beat per channel, per-channel handshake.
interface axis_traffic_gen_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] tdata;
  logic [NUM_CH-1:0]                 tvalid;
  logic [NUM_CH-1:0]                 tlast;
  logic [NUM_CH-1:0]                 tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_traffic_gen_mc.sv
// Multi-channel AXI-Stream traffic generator: NUM_CH framed packet streams plus a run-done flag.
// Define TRAFFIC_GEN_LFSR_EN to compile in the LFSR payload selected by mode.
module axis_tg_ch #(
  parameter int DATA_WIDTH = 64,
  parameter int CH         = 0,
  parameter int PKT_LEN    = 8,
  parameter int NUM_PKTS   = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_acc,
  input  logic                  mode,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  output logic                  tlast,
  output logic                  busy,
  output logic                  fin
);
  localparam int BW = $clog2(PKT_LEN) + 1;
  localparam int PW = $clog2(NUM_PKTS) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] beat;
  logic [PW-1:0] pkt;
  logic [31:0]   seq;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   low;
  logic          xfer, last_beat, last_pkt;

  assign tvalid    = (state == S_SEND);
  assign xfer      = tvalid & tready;
  assign last_beat = (beat == BW'(PKT_LEN - 1));
  assign last_pkt  = (pkt == PW'(NUM_PKTS - 1));
  assign tlast     = tvalid & last_beat;
  assign busy      = (state == S_SEND) || (state == S_GAP);
  assign fin       = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      beat    <= '0;
      pkt     <= '0;
      seq     <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_FIN: if (start_acc) begin
          state   <= S_SEND;
          beat    <= '0;
          pkt     <= '0;
          seq     <= '0;
          gap_cnt <= '0;
        end
        S_SEND: if (xfer) begin
          seq <= seq + 32'd1;
          if (last_beat) begin
            beat <= '0;
            if (last_pkt) state <= S_FIN;
            else begin
              pkt <= pkt + 1'b1;
              if (GAP_CYCLES > 0) begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end
          end else beat <= beat + 1'b1;
        end
        S_GAP: begin
          // gap_cnt counts idle cycles already spent; leave on the last one
          if (int'(gap_cnt) >= GAP_CYCLES - 1) state <= S_SEND;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TRAFFIC_GEN_LFSR_EN
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  logic [31:0] lfsr;
  logic        mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= '0;
      mode_q <= 1'b0;
    end else if (start_acc) begin
      lfsr   <= 32'hACE1_0000 | 32'(CH + 1);
      mode_q <= mode;
    end else if (xfer) begin
      lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
    end
  end

  assign low = mode_q ? lfsr : seq;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign low         = seq;
`endif

  // Payload only drives the bus while a beat is offered; idle lanes read as zero.
  always_comb begin
    tdata = '0;
    if (tvalid) begin
      tdata[DATA_WIDTH-1 -: 8] = 8'(CH);
      tdata[31:0]              = low;
    end
  end
endmodule

module axis_traffic_gen_mc #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 4,
  parameter int PKT_LEN    = 8,
  parameter int NUM_PKTS   = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  axis_traffic_gen_mc_if.master axis,
  output logic                  done
);
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] tdata;
  logic [NUM_CH-1:0]                 tvalid, tlast, busy, fin;
  logic                              start_acc;

  // A run request is dropped while any lane still has packets outstanding.
  assign start_acc = start & ~(|busy);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axis_tg_ch #(
      .DATA_WIDTH(DATA_WIDTH),
      .CH        (g),
      .PKT_LEN   (PKT_LEN),
      .NUM_PKTS  (NUM_PKTS),
      .GAP_CYCLES(GAP_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .start_acc(start_acc),
      .mode     (mode),
      .tready   (axis.tready[g]),
      .tdata    (tdata[g]),
      .tvalid   (tvalid[g]),
      .tlast    (tlast[g]),
      .busy     (busy[g]),
      .fin      (fin[g])
    );
  end

  assign axis.tdata  = tdata;
  assign axis.tvalid = tvalid;
  assign axis.tlast  = tlast;
  assign done        = &fin;
endmodule

// File: tb/tb_axis_traffic_gen_mc.sv
// Bench for axis_traffic_gen_mc: two instances (no gap / 2-cycle gap) checked every cycle against a stream-level model.
module tb_axis_traffic_gen_mc;
  localparam int DW    = 64;
  localparam int NC    = 4;
  localparam int PL    = 4;
  localparam int NP    = 2;
  localparam int TOTAL = PL * NP;
  localparam int GAPV [2] = '{0, 2};

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [NC-1:0] rdy [2];
  logic done0, done1;

  always #5 clk = ~clk;

  axis_traffic_gen_mc_if #(.NUM_CH(NC), .DATA_WIDTH(DW)) if0 ();
  axis_traffic_gen_mc_if #(.NUM_CH(NC), .DATA_WIDTH(DW)) if1 ();

  assign if0.tready = rdy[0];
  assign if1.tready = rdy[1];

  axis_traffic_gen_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .PKT_LEN(PL), .NUM_PKTS(NP), .GAP_CYCLES(0))
    u_dut0 (.clk(clk), .rst(rst), .start(start), .mode(mode), .axis(if0), .done(done0));
  axis_traffic_gen_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .PKT_LEN(PL), .NUM_PKTS(NP), .GAP_CYCLES(2))
    u_dut1 (.clk(clk), .rst(rst), .start(start), .mode(mode), .axis(if1), .done(done1));

  logic [NC-1:0]         o_vld [2];
  logic [NC-1:0]         o_lst [2];
  logic [NC-1:0][DW-1:0] o_dat [2];
  logic                  o_done [2];
  assign o_vld[0] = if0.tvalid;  assign o_vld[1] = if1.tvalid;
  assign o_lst[0] = if0.tlast;   assign o_lst[1] = if1.tlast;
  assign o_dat[0] = if0.tdata;   assign o_dat[1] = if1.tdata;
  assign o_done[0] = done0;      assign o_done[1] = done1;

  // Model: each lane is just "next beat number n of TOTAL" plus pending gap cycles.
  int          m_n   [2][NC];
  int          m_gap [2][NC];
  logic [31:0] m_lfsr[2][NC];
  bit          m_run [2];
  bit          m_mode[2];
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Galois form of x^32+x^22+x^2+x+1, shifting toward bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic bit m_valid(input int d, input int c);
    return m_run[d] && m_n[d][c] < TOTAL && m_gap[d][c] == 0;
  endfunction

  function automatic bit m_busy(input int d);
    bit b = 1'b0;
    for (int c = 0; c < NC; c++) if (m_run[d] && m_n[d][c] < TOTAL) b = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] m_data(input int d, input int c);
    logic [63:0] v = '0;
    if (m_valid(d, c)) begin
      v[63:56] = 8'(c);
      v[31:0]  = 32'(m_n[d][c]);
`ifdef TRAFFIC_GEN_LFSR_EN
      if (m_mode[d]) v[31:0] = m_lfsr[d][c];
`endif
    end
    return v;
  endfunction

  task automatic step_model();
    for (int d = 0; d < 2; d++) begin
      bit bz = m_busy(d);
      if (rst) begin
        m_run[d] = 0; m_mode[d] = 0;
        for (int c = 0; c < NC; c++) begin m_n[d][c] = 0; m_gap[d][c] = 0; m_lfsr[d][c] = '0; end
      end else if (start && !bz) begin
        m_run[d] = 1; m_mode[d] = mode;
        for (int c = 0; c < NC; c++) begin
          m_n[d][c] = 0; m_gap[d][c] = 0; m_lfsr[d][c] = 32'hACE1_0000 | 32'(c + 1);
        end
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (m_valid(d, c) && rdy[d][c]) begin
            m_n[d][c]++;
            m_lfsr[d][c] = lfsr_next(m_lfsr[d][c]);
            if (m_n[d][c] % PL == 0 && m_n[d][c] < TOTAL) m_gap[d][c] = GAPV[d];
          end else if (m_gap[d][c] > 0) m_gap[d][c]--;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      bit all_fin = m_run[d];
      for (int c = 0; c < NC; c++) begin
        bit v = m_valid(d, c);
        chk($sformatf("d%0d ch%0d tvalid", d, c), 64'(o_vld[d][c]), 64'(v));
        chk($sformatf("d%0d ch%0d tlast", d, c), 64'(o_lst[d][c]), 64'(v && (m_n[d][c] % PL == PL - 1)));
        chk($sformatf("d%0d ch%0d tdata", d, c), o_dat[d][c], m_data(d, c));
        if (m_n[d][c] != TOTAL) all_fin = 0;
      end
      chk($sformatf("d%0d done", d), 64'(o_done[d]), 64'(all_fin));
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit m, input logic [NC-1:0] t0, input logic [NC-1:0] t1);
    rst = r; start = s; mode = m; rdy[0] = t0; rdy[1] = t1;
    @(posedge clk);
    step_model();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [NC-1:0] rnd_rdy();
    logic [NC-1:0] t;
    for (int c = 0; c < NC; c++) t[c] = ($urandom_range(0, 99) < 70);
    return t;
  endfunction

  localparam logic [NC-1:0] ALL = '1;

  initial begin
    int lat;
    rdy[0] = ALL; rdy[1] = ALL;
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_mode[d] = 0;
      for (int c = 0; c < NC; c++) begin m_n[d][c] = 0; m_gap[d][c] = 0; m_lfsr[d][c] = '0; end
    end
    @(negedge clk);

    // reset, then idle with no start
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, ALL, ALL);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, ALL, ALL);

    // counter run, full-rate sink
    cycle(0, 1, 0, ALL, ALL);
    lat = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) cycle(0, 0, 0, ALL, ALL);
      if (k == 1) chk("ch2 first beat", o_dat[0][2], 64'h0200_0000_0000_0000);
      if (k == 8) chk("ch2 last beat", {o_lst[0][2], o_dat[0][2][62:0]}, {1'b1, 63'h0200_0000_0000_0007});
      if (lat == 0 && o_done[0]) lat = k;
    end
    chk("done latency", 64'(lat), 64'd9);

    // payload-mode run: LFSR when compiled in, otherwise plain counter
    cycle(0, 1, 1, ALL, ALL);
    chk("ch0 beat0 mode1", o_dat[0][0],
`ifdef TRAFFIC_GEN_LFSR_EN
        64'h0000_0000_ACE1_0001);
`else
        64'h0);
`endif
    cycle(0, 0, 1, ALL, ALL);
    chk("ch0 beat1 mode1", o_dat[0][0],
`ifdef TRAFFIC_GEN_LFSR_EN
        64'h0000_0000_D650_8003);
`else
        64'h1);
`endif
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, ALL, ALL);

    // ch1 stalls for 3 cycles while presenting sequence 2
    cycle(0, 1, 0, ALL, ALL);
    cycle(0, 0, 0, ALL, ALL);
    cycle(0, 0, 0, ALL, ALL);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'b1101, 4'b1101);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, ALL, ALL);

    // reset mid-packet while sequence 5 is on the bus, then restart
    cycle(0, 1, 0, ALL, ALL);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, ALL, ALL);
    chk("seq5 before rst", o_dat[0][0], 64'h5);
    cycle(1, 1, 0, ALL, ALL);
    cycle(0, 1, 0, ALL, ALL);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, ALL, ALL);

    // randomized traffic, starts, modes, resets
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 999) < 4, $urandom_range(0, 99) < 6, 1'($urandom), rnd_rdy(), rnd_rdy());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
